dcache_tag_ctrl: RTL

Sequencing and arbitration controller for the data cache tag RAM (256 entries x 21 bits, write-first, one-cycle registered read). It clears every entry after reset and on a global invalidate request, and shares the RAM between a lookup port (read, hit compare) and an update port (fill / dirty / invalidate writes). It sits between the dcache core control logic and the tag RAM instance.

---
 rtl/dcache_tag_ctrl_if.sv | 38 +++
 rtl/dcache_tag_ctrl.sv | 62 ++++++
 2 files changed

// File: rtl/dcache_tag_ctrl_if.sv
// dcache_tag_ctrl_if: core-side lookup/update/invalidate signals and tag RAM port signals.
// The controller takes the slave view; the core plus RAM environment takes the master view.
interface dcache_tag_ctrl_if;
    logic        lookup_valid_i;
    logic [31:0] lookup_addr_i;
    logic        lookup_accept_o;
    logic        resp_valid_o;
    logic        resp_hit_o;
    logic        resp_dirty_o;
    logic [18:0] resp_tag_o;
    logic        upd_valid_i;
    logic [31:0] upd_addr_i;
    logic        upd_valid_bit_i;
    logic        upd_dirty_i;
    logic        upd_accept_o;
    logic        inval_all_i;
    logic        busy_o;
    logic        inval_done_o;
    logic [7:0]  tag_addr0_o;
    logic [20:0] tag_data0_i;
    logic [7:0]  tag_addr1_o;
    logic [20:0] tag_data1_o;
    logic        tag_wr1_o;

    modport slave (
        input  lookup_valid_i, lookup_addr_i, upd_valid_i, upd_addr_i, upd_valid_bit_i,
               upd_dirty_i, inval_all_i, tag_data0_i,
        output lookup_accept_o, resp_valid_o, resp_hit_o, resp_dirty_o, resp_tag_o,
               upd_accept_o, busy_o, inval_done_o, tag_addr0_o, tag_addr1_o, tag_data1_o, tag_wr1_o
    );

    modport master (
        output lookup_valid_i, lookup_addr_i, upd_valid_i, upd_addr_i, upd_valid_bit_i,
               upd_dirty_i, inval_all_i, tag_data0_i,
        input  lookup_accept_o, resp_valid_o, resp_hit_o, resp_dirty_o, resp_tag_o,
               upd_accept_o, busy_o, inval_done_o, tag_addr0_o, tag_addr1_o, tag_data1_o, tag_wr1_o
    );
endinterface

// File: rtl/dcache_tag_ctrl.sv
// dcache_tag_ctrl: clears the 256-entry tag RAM after reset / global invalidate and
// arbitrates the RAM read port (lookups) and write port (fills, dirty, invalidate writes).
module dcache_tag_ctrl (
    input  logic             clk_i,
    input  logic             rst_i,
    dcache_tag_ctrl_if.slave bus
);
    typedef enum logic [1:0] {INIT, SWEEP, IDLE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        resp_valid_q, resp_valid_d;
    logic [18:0] req_tag_q, req_tag_d;
    logic        done_q, done_d;
    logic        idle, lk_acc, up_acc;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            req_tag_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            req_tag_q    <= req_tag_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        idle    = state_q == IDLE;
        lk_acc  = idle && bus.lookup_valid_i;
        up_acc  = idle && bus.upd_valid_i;
        state_d = state_q;
        case (state_q)
            INIT:    state_d = SWEEP;
            SWEEP:   state_d = cnt_q == 8'hff ? IDLE : SWEEP;
            default: state_d = bus.inval_all_i ? SWEEP : IDLE;
        endcase
        // counter rests at zero outside SWEEP so every sweep starts from index 0
        cnt_d        = state_q == SWEEP ? cnt_q + 8'd1 : 8'd0;
        done_d       = state_q == SWEEP && cnt_q == 8'hff;
        resp_valid_d = lk_acc;
        req_tag_d    = lk_acc ? bus.lookup_addr_i[31:13] : req_tag_q;
        bus.lookup_accept_o = lk_acc;
        bus.upd_accept_o    = up_acc;
        bus.busy_o          = !idle;
        bus.inval_done_o    = done_q;
        bus.tag_addr0_o     = idle ? bus.lookup_addr_i[12:5] : 8'd0;
        bus.tag_addr1_o     = idle ? bus.upd_addr_i[12:5] : cnt_q;
        bus.tag_data1_o     = idle ? {bus.upd_valid_bit_i, bus.upd_dirty_i, bus.upd_addr_i[31:13]} : 21'd0;
        bus.tag_wr1_o       = state_q == SWEEP || up_acc;
        // RAM data arrives one cycle after the read index; gate it with the registered flag
        bus.resp_valid_o = resp_valid_q;
        bus.resp_hit_o   = resp_valid_q && bus.tag_data0_i[20] && bus.tag_data0_i[18:0] == req_tag_q;
        bus.resp_dirty_o = resp_valid_q && bus.tag_data0_i[19];
        bus.resp_tag_o   = resp_valid_q ? bus.tag_data0_i[18:0] : 19'd0;
    end
endmodule
